// File: rtl/sysmem_icb_arb2_pkg.sv
// Shared constants and master ID encoding for the two-master sysmem ICB arbiter.
package sysmem_icb_arb2_pkg;

    localparam int unsigned ICB_AW = 32;
    localparam int unsigned ICB_DW = 32;

    typedef enum logic {
        MID_M0 = 1'b0,
        MID_M1 = 1'b1
    } mid_e;

endpackage

// File: rtl/sysmem_icb_arb2_idfifo.sv
// In-order outstanding-ID FIFO: one bit per outstanding command naming the issuing master.
module sysmem_icb_arb_idfifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     din,
    input  logic                     pop,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sysmem_icb_arb2.sv
// Round-robin arbiter sharing one sysmem ICB port between two masters, with
// in-order response routing through an outstanding-ID FIFO.
module sysmem_icb_arb2
    import sysmem_icb_arb2_pkg::*;
#(
    parameter int unsigned AW         = ICB_AW,
    parameter int unsigned DW         = ICB_DW,
    parameter int unsigned OUTS_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          m0_icb_cmd_valid,
    output logic                          m0_icb_cmd_ready,
    input  logic [AW-1:0]                 m0_icb_cmd_addr,
    input  logic                          m0_icb_cmd_read,
    input  logic [DW-1:0]                 m0_icb_cmd_wdata,
    input  logic [DW/8-1:0]               m0_icb_cmd_wmask,
    output logic                          m0_icb_rsp_valid,
    input  logic                          m0_icb_rsp_ready,
    output logic                          m0_icb_rsp_err,
    output logic [DW-1:0]                 m0_icb_rsp_rdata,
    input  logic                          m1_icb_cmd_valid,
    output logic                          m1_icb_cmd_ready,
    input  logic [AW-1:0]                 m1_icb_cmd_addr,
    input  logic                          m1_icb_cmd_read,
    input  logic [DW-1:0]                 m1_icb_cmd_wdata,
    input  logic [DW/8-1:0]               m1_icb_cmd_wmask,
    output logic                          m1_icb_rsp_valid,
    input  logic                          m1_icb_rsp_ready,
    output logic                          m1_icb_rsp_err,
    output logic [DW-1:0]                 m1_icb_rsp_rdata,
    output logic                          s_icb_cmd_valid,
    input  logic                          s_icb_cmd_ready,
    output logic [AW-1:0]                 s_icb_cmd_addr,
    output logic                          s_icb_cmd_read,
    output logic [DW-1:0]                 s_icb_cmd_wdata,
    output logic [DW/8-1:0]               s_icb_cmd_wmask,
    input  logic                          s_icb_rsp_valid,
    output logic                          s_icb_rsp_ready,
    input  logic                          s_icb_rsp_err,
    input  logic [DW-1:0]                 s_icb_rsp_rdata,
    output logic [$clog2(OUTS_DEPTH):0]   outs_cnt,
    output logic                          unexp_rsp
);

    mid_e prio_q;
    mid_e lock_id_q;
    mid_e grant;
    logic lock_q;
    logic unexp_q;
    logic gnt_valid;
    logic gnt_m1;
    logic cmd_hs;
    logic fifo_full;
    logic fifo_empty;
    logic head_id;
    logic head_m1;
    logic rsp_pop;

    always_comb begin
        grant = MID_M0;
        if (lock_q) begin
            grant = lock_id_q;
        end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
            grant = prio_q;
        end else if (m1_icb_cmd_valid) begin
            grant = MID_M1;
        end
    end

    assign gnt_m1           = (grant == MID_M1);
    assign gnt_valid        = gnt_m1 ? m1_icb_cmd_valid : m0_icb_cmd_valid;
    // Only the registered full flag gates commands, keeping rsp->cmd paths apart.
    assign s_icb_cmd_valid  = gnt_valid & ~fifo_full;
    assign s_icb_cmd_addr   = gnt_m1 ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_read   = gnt_m1 ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_wdata  = gnt_m1 ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_cmd_wmask  = gnt_m1 ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
    assign m0_icb_cmd_ready = ~gnt_m1 & s_icb_cmd_ready & ~fifo_full;
    assign m1_icb_cmd_ready =  gnt_m1 & s_icb_cmd_ready & ~fifo_full;
    assign cmd_hs           = s_icb_cmd_valid & s_icb_cmd_ready;

    assign head_m1          = head_id;
    assign m0_icb_rsp_valid = ~fifo_empty & ~head_m1 & s_icb_rsp_valid;
    assign m1_icb_rsp_valid = ~fifo_empty &  head_m1 & s_icb_rsp_valid;
    assign m0_icb_rsp_err   = s_icb_rsp_err;
    assign m1_icb_rsp_err   = s_icb_rsp_err;
    assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
    assign s_icb_rsp_ready  = fifo_empty | (head_m1 ? m1_icb_rsp_ready : m0_icb_rsp_ready);
    assign rsp_pop          = ~fifo_empty & s_icb_rsp_valid & s_icb_rsp_ready;
    assign unexp_rsp        = unexp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q    <= MID_M0;
            lock_q    <= 1'b0;
            lock_id_q <= MID_M0;
            unexp_q   <= 1'b0;
        end else begin
            if (cmd_hs) begin
                prio_q <= gnt_m1 ? MID_M0 : MID_M1;
                lock_q <= 1'b0;
            end else if (s_icb_cmd_valid) begin
                lock_q    <= 1'b1;
                lock_id_q <= grant;
            end
            if (fifo_empty && s_icb_rsp_valid) begin
                unexp_q <= 1'b1;
            end
        end
    end

    sysmem_icb_arb_idfifo #(
        .DEPTH (OUTS_DEPTH)
    ) u_idfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_hs),
        .din   (gnt_m1),
        .pop   (rsp_pop),
        .dout  (head_id),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outs_cnt)
    );

endmodule
